// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch stage.
// Issues instruction memory requests over a req/ack handshake and presents
// fetched words to decode through an output slot backed by a one-entry skid
// buffer. A taken branch redirects the PC, kills younger work and pulses flush.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        br_valid,
   input  logic        should_branch,
   input  logic [31:0] br_target,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        flush
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_addr_q, req_addr_d;
   logic        if_valid_q, if_valid_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_instr_q, if_instr_d;
   logic        skid_valid_q, skid_valid_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic        flush_q, flush_d;

   logic        redirect;
   logic        consume;
   logic [31:0] pc_plus4;
   logic [31:0] target_aligned;

   assign redirect       = br_valid & should_branch;
   assign consume        = if_valid_q & ~stall;
   assign pc_plus4       = pc_q + 32'd4;
   assign target_aligned = br_target & ~32'h0000_0003;

   // State register and all datapath flops, cleared asynchronously by rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         pc_q         <= RESET_PC;
         req_addr_q   <= RESET_PC;
         if_valid_q   <= 1'b0;
         if_pc_q      <= 32'h0000_0000;
         if_instr_q   <= NOP_INSTR;
         skid_valid_q <= 1'b0;
         skid_pc_q    <= 32'h0000_0000;
         skid_instr_q <= NOP_INSTR;
         flush_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_addr_q   <= req_addr_d;
         if_valid_q   <= if_valid_d;
         if_pc_q      <= if_pc_d;
         if_instr_q   <= if_instr_d;
         skid_valid_q <= skid_valid_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
         flush_q      <= flush_d;
      end
   end

   // Next-state and slot update logic; a taken redirect overrides everything.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      req_addr_d   = req_addr_q;
      if_valid_d   = if_valid_q;
      if_pc_d      = if_pc_q;
      if_instr_d   = if_instr_q;
      skid_valid_d = skid_valid_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      flush_d      = 1'b0;

      if (consume) begin
         if_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            state_d    = ST_FETCH;
            req_addr_d = pc_q;
         end
         ST_FETCH: begin
            if (imem_ack) begin
               pc_d       = pc_plus4;
               req_addr_d = pc_plus4;
               if (!if_valid_q || consume) begin
                  if_valid_d = 1'b1;
                  if_pc_d    = req_addr_q;
                  if_instr_d = imem_rdata;
               end else begin
                  skid_valid_d = 1'b1;
                  skid_pc_d    = req_addr_q;
                  skid_instr_d = imem_rdata;
                  state_d      = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (consume) begin
               if_valid_d   = skid_valid_q;
               if_pc_d      = skid_pc_q;
               if_instr_d   = skid_instr_q;
               skid_valid_d = 1'b0;
               req_addr_d   = pc_q;
               state_d      = ST_FETCH;
            end
         end
         ST_DRAIN: begin
            if (imem_ack) begin
               req_addr_d = pc_q;
               state_d    = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (redirect) begin
         pc_d         = target_aligned;
         if_valid_d   = 1'b0;
         if_instr_d   = NOP_INSTR;
         skid_valid_d = 1'b0;
         flush_d      = 1'b1;
         if ((state_q == ST_FETCH || state_q == ST_DRAIN) && !imem_ack) begin
            // An outstanding request must complete on its stale address first.
            state_d = ST_DRAIN;
         end else begin
            state_d    = ST_FETCH;
            req_addr_d = target_aligned;
         end
      end
   end

   // Output decode: requests are only on the bus while fetching or draining.
   always_comb begin
      imem_req  = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
      imem_addr = req_addr_q;
      if_valid  = if_valid_q;
      if_pc     = if_pc_q;
      if_instr  = if_instr_q;
      flush     = flush_q;
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: directed scenarios plus a randomized run
// checked against a program-order model of the instruction stream.
module tb_pc_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0100;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        br_valid;
   logic        should_branch;
   logic [31:0] br_target;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        flush;

   int n_cmp = 0;
   int n_err = 0;

   // Memory responder state: latency mode 0 = zero-wait, 1 = ack on the third
   // request cycle, 2 = random 0..3 wait cycles.
   int          lat_mode;
   int          lat_cnt;
   bit          mem_busy;
   bit          spur_en;
   logic        ack_ok;
   logic [31:0] data_key;

   // Values seen during the most recent cycle, before its rising edge.
   logic        s_req, s_ack, s_consume, s_redirect;
   logic [31:0] s_addr, s_pc, s_instr;

   pc_fetch_unit #(
      .RESET_PC  (RESET_PC),
      .NOP_INSTR (NOP)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .br_valid      (br_valid),
      .should_branch (should_branch),
      .br_target     (br_target),
      .stall         (stall),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .if_valid      (if_valid),
      .if_pc         (if_pc),
      .if_instr      (if_instr),
      .flush         (flush)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   assign imem_ack   = ack_ok;
   assign imem_rdata = imem_addr ^ data_key;

   // Drive one cycle of inputs at the falling edge, let the rising edge happen,
   // and return 1 time unit after it with the memory model advanced.
   task automatic run_cycle(input logic stl, input logic bv, input logic sb,
                            input logic [31:0] tgt);
      @(negedge clk);
      stall         = stl;
      br_valid      = bv;
      should_branch = sb;
      br_target     = tgt;
      if (imem_req && !mem_busy) begin
         mem_busy = 1'b1;
         case (lat_mode)
            0:       lat_cnt = 0;
            1:       lat_cnt = 2;
            default: lat_cnt = $urandom_range(0, 3);
         endcase
      end
      if (imem_req) ack_ok = (lat_cnt == 0);
      else          ack_ok = spur_en && ($urandom_range(0, 3) == 0);
      s_req      = imem_req;
      s_ack      = ack_ok;
      s_addr     = imem_addr;
      s_consume  = if_valid && !stl;
      s_pc       = if_pc;
      s_instr    = if_instr;
      s_redirect = bv && sb;
      @(posedge clk);
      #1;
      if (s_req) begin
         if (s_ack) mem_busy = 1'b0;
         else       lat_cnt  = lat_cnt - 1;
      end
   endtask

   // Assert reset for two edges and return 1 time unit after an edge; the
   // caller releases rst_n.
   task automatic do_reset();
      rst_n         = 1'b0;
      stall         = 1'b0;
      br_valid      = 1'b0;
      should_branch = 1'b0;
      br_target     = 32'h0;
      ack_ok        = 1'b0;
      mem_busy      = 1'b0;
      lat_cnt       = 0;
      spur_en       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      lat_mode = 0;
      data_key = 32'h0;
      do_reset();
      n_cmp++;
      if ({if_valid, if_pc, if_instr, flush, imem_req} !== {1'b0, 32'h0, NOP, 1'b0, 1'b0}) begin
         n_err++;
         $display("[TB] FAIL reset_outputs: got v=%b pc=%h instr=%h flush=%b req=%b, expected v=0 pc=0 instr=%h flush=0 req=0",
                  if_valid, if_pc, if_instr, flush, imem_req, NOP);
      end
      rst_n = 1'b1;
      run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      n_cmp++;
      if ({imem_req, imem_addr} !== {1'b1, RESET_PC}) begin
         n_err++;
         $display("[TB] FAIL first_request: got req=%b addr=%h, expected req=1 addr=%h",
                  imem_req, imem_addr, RESET_PC);
      end
   endtask

   task automatic test_sequential();
      logic [31:0] exp_pc;
      do_reset();
      rst_n = 1'b1;
      run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
         exp_pc = RESET_PC + 32'(4 * i);
         n_cmp++;
         if ({if_valid, if_pc, if_instr, flush} !== {1'b1, exp_pc, exp_pc, 1'b0}) begin
            n_err++;
            $display("[TB] FAIL sequential_%0d: got v=%b pc=%h instr=%h flush=%b, expected v=1 pc=%h instr=%h flush=0",
                     i, if_valid, if_pc, if_instr, flush, exp_pc, exp_pc);
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      rst_n = 1'b1;
      repeat (3) run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
         n_cmp++;
         if ({if_valid, if_pc, imem_req} !== {1'b1, 32'h104, 1'b0}) begin
            n_err++;
            $display("[TB] FAIL stall_hold_%0d: got v=%b pc=%h req=%b, expected v=1 pc=104 req=0",
                     i, if_valid, if_pc, imem_req);
         end
      end
      run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      n_cmp++;
      if ({if_valid, if_pc, if_instr, imem_req, imem_addr} !== {1'b1, 32'h108, 32'h108, 1'b1, 32'h10C}) begin
         n_err++;
         $display("[TB] FAIL stall_skid_out: got v=%b pc=%h instr=%h req=%b addr=%h, expected v=1 pc=108 instr=108 req=1 addr=10c",
                  if_valid, if_pc, if_instr, imem_req, imem_addr);
      end
      run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      n_cmp++;
      if ({if_valid, if_pc} !== {1'b1, 32'h10C}) begin
         n_err++;
         $display("[TB] FAIL stall_resume: got v=%b pc=%h, expected v=1 pc=10c", if_valid, if_pc);
      end
   endtask

   task automatic test_branch();
      do_reset();
      rst_n = 1'b1;
      repeat (9) run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      run_cycle(1'b0, 1'b1, 1'b1, 32'h0000_2002);
      n_cmp++;
      if ({flush, if_valid, if_instr, imem_req, imem_addr} !== {1'b1, 1'b0, NOP, 1'b1, 32'h2000}) begin
         n_err++;
         $display("[TB] FAIL branch_flush: got flush=%b v=%b instr=%h req=%b addr=%h, expected flush=1 v=0 instr=%h req=1 addr=2000",
                  flush, if_valid, if_instr, imem_req, imem_addr, NOP);
      end
      run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      n_cmp++;
      if ({flush, if_valid, if_pc, if_instr} !== {1'b0, 1'b1, 32'h2000, 32'h2000}) begin
         n_err++;
         $display("[TB] FAIL branch_target: got flush=%b v=%b pc=%h instr=%h, expected flush=0 v=1 pc=2000 instr=2000",
                  flush, if_valid, if_pc, if_instr);
      end
      run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      n_cmp++;
      if ({if_valid, if_pc} !== {1'b1, 32'h2004}) begin
         n_err++;
         $display("[TB] FAIL branch_next: got v=%b pc=%h, expected v=1 pc=2004", if_valid, if_pc);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_seq [3];
      exp_seq[0] = 32'hFFFF_FFF8;
      exp_seq[1] = 32'hFFFF_FFFC;
      exp_seq[2] = 32'h0000_0000;
      run_cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9);
      for (int i = 0; i < 3; i++) begin
         run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
         n_cmp++;
         if ({if_valid, if_pc, if_instr} !== {1'b1, exp_seq[i], exp_seq[i]}) begin
            n_err++;
            $display("[TB] FAIL wrap_%0d: got v=%b pc=%h instr=%h, expected v=1 pc=%h",
                     i, if_valid, if_pc, if_instr, exp_seq[i]);
         end
      end
   endtask

   task automatic test_not_taken();
      logic [31:0] exp_pc;
      do_reset();
      rst_n = 1'b1;
      repeat (2) run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         run_cycle(1'b0, (i == 0), (i == 1), 32'h0000_4440);
         exp_pc = 32'h104 + 32'(4 * i);
         n_cmp++;
         if ({if_valid, if_pc, flush} !== {1'b1, exp_pc, 1'b0}) begin
            n_err++;
            $display("[TB] FAIL not_taken_%0d: got v=%b pc=%h flush=%b, expected v=1 pc=%h flush=0",
                     i, if_valid, if_pc, flush, exp_pc);
         end
      end
   endtask

   task automatic test_drain();
      do_reset();
      rst_n = 1'b1;
      repeat (4) run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      lat_mode = 1;
      run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      n_cmp++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h10C}) begin
         n_err++;
         $display("[TB] FAIL drain_req: got req=%b addr=%h, expected req=1 addr=10c", imem_req, imem_addr);
      end
      run_cycle(1'b0, 1'b1, 1'b1, 32'h0000_0400);
      n_cmp++;
      if ({flush, if_valid, imem_req, imem_addr} !== {1'b1, 1'b0, 1'b1, 32'h10C}) begin
         n_err++;
         $display("[TB] FAIL drain_hold: got flush=%b v=%b req=%b addr=%h, expected flush=1 v=0 req=1 addr=10c",
                  flush, if_valid, imem_req, imem_addr);
      end
      for (int i = 0; i < 3; i++) begin
         run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
         n_cmp++;
         if ({flush, if_valid, imem_req, imem_addr} !== {1'b0, 1'b0, 1'b1, 32'h400}) begin
            n_err++;
            $display("[TB] FAIL drain_refetch_%0d: got flush=%b v=%b req=%b addr=%h, expected flush=0 v=0 req=1 addr=400",
                     i, flush, if_valid, imem_req, imem_addr);
         end
      end
      run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      n_cmp++;
      if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h400, 32'h400}) begin
         n_err++;
         $display("[TB] FAIL drain_target: got v=%b pc=%h instr=%h, expected v=1 pc=400 instr=400",
                  if_valid, if_pc, if_instr);
      end
   endtask

   task automatic test_async_reset();
      lat_mode = 0;
      run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      n_cmp++;
      if ({imem_req, if_valid} !== {1'b1, 1'b1}) begin
         n_err++;
         $display("[TB] FAIL async_pre: got req=%b v=%b, expected req=1 v=1", imem_req, if_valid);
      end
      @(negedge clk);
      #2;
      rst_n    = 1'b0;
      ack_ok   = 1'b0;
      mem_busy = 1'b0;
      lat_cnt  = 0;
      #1;
      n_cmp++;
      if ({if_valid, if_pc, if_instr, flush, imem_req, imem_addr} !== {1'b0, 32'h0, NOP, 1'b0, 1'b0, RESET_PC}) begin
         n_err++;
         $display("[TB] FAIL async_reset: got v=%b pc=%h instr=%h flush=%b req=%b addr=%h, expected all reset values",
                  if_valid, if_pc, if_instr, flush, imem_req, imem_addr);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      n_cmp++;
      if ({if_valid, if_pc} !== {1'b1, RESET_PC}) begin
         n_err++;
         $display("[TB] FAIL async_restart: got v=%b pc=%h, expected v=1 pc=%h", if_valid, if_pc, RESET_PC);
      end
   endtask

   // Randomized run: every instruction decode accepts must be the next one in
   // program order, where a taken branch restarts the order at its target.
   task automatic test_random();
      logic [31:0] exp_pc;
      logic [31:0] tgt;
      logic        stl, bv, sb;
      int          consumed;
      lat_mode = 2;
      data_key = $urandom;
      do_reset();
      spur_en  = 1'b1;
      rst_n    = 1'b1;
      exp_pc   = RESET_PC;
      consumed = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         stl = ($urandom_range(0, 3) == 0);
         bv  = ($urandom_range(0, 9) == 0);
         sb  = $urandom_range(0, 1) == 1;
         tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         run_cycle(stl, bv, sb, tgt);
         if (s_consume) begin
            n_cmp++;
            if ({s_pc, s_instr} !== {exp_pc, exp_pc ^ data_key}) begin
               n_err++;
               $display("[TB] FAIL random_stream cyc %0d: got pc=%h instr=%h, expected pc=%h instr=%h",
                        cyc, s_pc, s_instr, exp_pc, exp_pc ^ data_key);
            end
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
         if (s_redirect) exp_pc = tgt & ~32'h3;
         n_cmp++;
         if (flush !== s_redirect) begin
            n_err++;
            $display("[TB] FAIL random_flush cyc %0d: got %b expected %b", cyc, flush, s_redirect);
         end
         if (s_redirect) begin
            n_cmp++;
            if ({if_valid, if_instr} !== {1'b0, NOP}) begin
               n_err++;
               $display("[TB] FAIL random_kill cyc %0d: got v=%b instr=%h expected v=0 instr=%h",
                        cyc, if_valid, if_instr, NOP);
            end
         end
         if (s_req && !s_ack) begin
            n_cmp++;
            if ({imem_req, imem_addr} !== {1'b1, s_addr}) begin
               n_err++;
               $display("[TB] FAIL random_handshake cyc %0d: got req=%b addr=%h expected req=1 addr=%h",
                        cyc, imem_req, imem_addr, s_addr);
            end
         end
      end
      n_cmp++;
      if (consumed < 100) begin
         n_err++;
         $display("[TB] FAIL random_progress: got %0d instructions, expected at least 100", consumed);
      end
   endtask

   // Sequence all scenarios and report.
   initial begin
      lat_mode = 0;
      lat_cnt  = 0;
      mem_busy = 1'b0;
      spur_en  = 1'b0;
      ack_ok   = 1'b0;
      data_key = 32'h0;
      test_reset();
      test_sequential();
      test_stall();
      test_branch();
      test_wrap();
      test_not_taken();
      test_drain();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Safety net against a stuck simulation.
   initial begin
      #500000;
      $display("[TB] FAIL timeout: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_err);
      $fatal(1, "[TB] timeout");
   end

endmodule
